// File: rtl/tc_io_pkg.sv
// Shared defaults for the TinyComp I/O responder: word width and FIFO depth.
package tc_io_pkg;

  localparam int unsigned TC_IO_WIDTH      = 32;
  localparam int unsigned TC_IO_DEPTH_LOG2 = 4;
  localparam int unsigned TC_IO_DEPTH      = 1 << TC_IO_DEPTH_LOG2;

endpackage

// File: rtl/tc_io_fifo.sv
// Synchronous fall-through FIFO with a zero-latency head; head reads 0 when empty.
// A push is refused when full as seen before any same-cycle pop.
module tc_io_fifo #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned PW    = DEPTH_LOG2 + 1;

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             push_ok;
  logic             pop_ok;

  // Pointers carry a wrap bit above the index to tell full from empty.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                   (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign head    = empty ? '0 : mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (push_ok) begin
      mem_d[wr_ptr_q[DEPTH_LOG2-1:0]] = push_data;
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/tc_io_responder.sv
// Peripheral-side responder for TinyComp Input/Output instructions, one FIFO per direction.
// Optional Loopback port (output FIFO feeds input FIFO) is built when TC_IO_LOOPBACK_EN is defined.
module tc_io_responder
  import tc_io_pkg::*;
#(
  parameter int unsigned WIDTH      = TC_IO_WIDTH,
  parameter int unsigned DEPTH_LOG2 = TC_IO_DEPTH_LOG2
) (
  input  logic             Ph0,
  input  logic             Reset,
`ifdef TC_IO_LOOPBACK_EN
  input  logic             Loopback,
`endif
  input  logic             InStrobe,
  input  logic             OutStrobe,
  input  logic [WIDTH-1:0] OutData,
  output logic [WIDTH-1:0] InData,
  output logic             InRdy,
  input  logic [WIDTH-1:0] DevInData,
  input  logic             DevInValid,
  output logic             DevInReady,
  output logic [WIDTH-1:0] DevOutData,
  output logic             DevOutValid,
  input  logic             DevOutReady,
  output logic             Underflow,
  output logic             Overflow
);

  logic             loopback;
  logic             in_full, in_empty, out_full, out_empty;
  logic             in_push, in_pop, out_pop, lb_xfer;
  logic [WIDTH-1:0] in_push_data, out_head;
  logic             underflow_q, underflow_d;
  logic             overflow_q, overflow_d;

`ifdef TC_IO_LOOPBACK_EN
  assign loopback = Loopback;
`else
  assign loopback = 1'b0;
`endif

  // In loopback the device side is masked and words move output FIFO -> input FIFO.
  assign lb_xfer      = loopback & ~out_empty & ~in_full;
  assign DevInReady   = ~loopback & ~in_full;
  assign DevOutValid  = ~loopback & ~out_empty;
  assign DevOutData   = out_head;
  assign InRdy        = ~in_empty;
  assign in_push      = loopback ? lb_xfer : (DevInValid & DevInReady);
  assign in_push_data = loopback ? out_head : DevInData;
  assign in_pop       = InStrobe & InRdy;
  assign out_pop      = loopback ? lb_xfer : (DevOutValid & DevOutReady);

  tc_io_fifo #(.WIDTH(WIDTH), .DEPTH_LOG2(DEPTH_LOG2)) u_in_fifo (
    .clk       (Ph0),
    .reset     (Reset),
    .push      (in_push),
    .push_data (in_push_data),
    .pop       (in_pop),
    .full      (in_full),
    .empty     (in_empty),
    .head      (InData)
  );

  tc_io_fifo #(.WIDTH(WIDTH), .DEPTH_LOG2(DEPTH_LOG2)) u_out_fifo (
    .clk       (Ph0),
    .reset     (Reset),
    .push      (OutStrobe),
    .push_data (OutData),
    .pop       (out_pop),
    .full      (out_full),
    .empty     (out_empty),
    .head      (out_head)
  );

  // Sticky error flags, cleared only by reset.
  always_comb begin
    underflow_d = underflow_q | (InStrobe & in_empty);
    overflow_d  = overflow_q | (OutStrobe & out_full);
  end

  always_ff @(posedge Ph0) begin
    if (Reset) begin
      underflow_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      underflow_q <= underflow_d;
      overflow_q  <= overflow_d;
    end
  end

  assign Underflow = underflow_q;
  assign Overflow  = overflow_q;

endmodule

// File: doc/tc_io_responder.md
Name: tc_io_responder

Overview:
- Peripheral-side responder for the TinyComp I/O instructions.
- Presents `InData`/`InRdy` to the CPU and consumes words on `InStrobe`. Captures CPU output words on `OutStrobe`.
- Buffers each direction in a small FIFO, with external valid/ready streams on the device side.
- Sits between the CPU core and a byte/word device (UART bridge, host link) in the same Ph0 clock domain.

Parameters:
- WIDTH, 32, data word width; matches CPU register width.
- DEPTH_LOG2, 4, log2 of each FIFO depth (16 entries).

Ports:
- Ph0  input  1  CPU instruction clock; all state updates on its rising edge.
- Reset  input  1  synchronous, active-high reset.
- InStrobe  input  1  CPU is executing an Input instruction this cycle.
- OutStrobe  input  1  CPU is executing an Output instruction this cycle.
- OutData  input  WIDTH  CPU output word (register-file port A), valid while OutStrobe=1.
- InData  output  WIDTH  head word of the input FIFO (fall-through), to the CPU.
- InRdy  output  1  input FIFO non-empty; drives the CPU skip test.
- DevInData  input  WIDTH  device-to-CPU word.
- DevInValid  input  1  DevInData valid.
- DevInReady  output  1  input FIFO not full.
- DevOutData  output  WIDTH  head word of the output FIFO.
- DevOutValid  output  1  output FIFO non-empty.
- DevOutReady  input  1  device accepts DevOutData.
- Underflow  output  1  sticky: InStrobe seen while input FIFO empty.
- Overflow  output  1  sticky: OutStrobe seen while output FIFO full.

Behaviour:
- Reset (synchronous, active-high, Reset): both FIFOs empty and pointers 0. InRdy=0, InData=0, DevInReady=1, DevOutValid=0, DevOutData=0, Underflow=0, Overflow=0. Reset mid-transfer discards all buffered words.
- Each FIFO has 2^DEPTH_LOG2 entries. Pointers are DEPTH_LOG2+1 bits with a wrap bit: full when indices are equal and wrap bits differ; empty when pointers are equal. Pointers wrap modulo 2^(DEPTH_LOG2+1).
- Outputs are fall-through with zero-latency head: InData and DevOutData are combinational from the head entry and forced to 0 when the FIFO is empty.

Input path:
- Push when DevInValid & DevInReady at the Ph0 edge.
- Pop when InStrobe & InRdy at the Ph0 edge. InRdy is therefore valid for the whole cycle in which the CPU samples it.
- InStrobe while empty: no pop, Underflow<=1, InData reads 0.
- Simultaneous push and pop: allowed in any state, including full. When full, a pop frees a slot that cycle, but DevInReady stays combinationally 0 when full, so no push happens that cycle.
- A pushed word is visible on InData one cycle after the push edge; there is no same-cycle bypass.

Output path:
- Push when OutStrobe at the Ph0 edge and not full.
- OutStrobe while full: word dropped, Overflow<=1.
- Pop when DevOutValid & DevOutReady.
- Simultaneous push and pop while full: the push is still rejected, because full is evaluated before the pop.

Sticky flags and timing:
- Underflow and Overflow clear only on Reset.
- InStrobe and OutStrobe both high is illegal CPU behaviour. Each path acts independently anyway.
- Occupancy counts never exceed 2^DEPTH_LOG2. Latency through either FIFO is 1 cycle minimum.

Optional Feature:
- Macro: TC_IO_LOOPBACK_EN.
- Defined: adds input port Loopback (1 bit). When Loopback=1:
  - Output FIFO pops feed the input FIFO push; the device side is ignored.
  - DevInReady=0 and DevOutValid=0.
  - A transfer occurs whenever the output FIFO is non-empty and the input FIFO is not full.
  - Loopback=0 restores normal device streaming.
- Undefined: the port is absent and the datapath is exactly as above.

Decomposition:
- Package tc_io_pkg: WIDTH and DEPTH_LOG2 defaults, plus localparam DEPTH = 1<<DEPTH_LOG2.
- Sub-module tc_io_fifo: synchronous fall-through FIFO with push/pop/full/empty/head. It is instantiated twice (input and output paths).
- Strobe qualification and sticky flags live in the top level.

Test Plan:
- Reset then DevIn push 0x0000_00A5 → next cycle InRdy=1, InData=0x0000_00A5. InStrobe one cycle → InRdy=0, InData=0, Underflow=0.
- InStrobe with input FIFO empty → Underflow=1 and stays 1 until Reset. No pointer movement: a following DevIn push of 0x1234 reads back as 0x1234.
- With DevOutReady=0, issue 17 OutStrobes carrying 1..17 → DevOutValid=1, Overflow=1. Drain → exactly 1..16 in order.
- Fill input FIFO with 16 words; assert DevInValid and InStrobe the same cycle → DevInReady=0, one pop, count 15. Next cycle the push lands and count is 16.
- Stream 40 words each way with random valid/ready/strobe gaps → order preserved across pointer wrap, no loss, flags 0.
- TC_IO_LOOPBACK_EN with Loopback=1: OutStrobe 0xDEAD_BEEF → within 2 cycles InRdy=1, InData=0xDEAD_BEEF, DevOutValid never asserted. Reset mid-stream empties both FIFOs.
